cuenta1: RTL and testbench

CUENTA1 -- requirements
Module: cuenta1

---
 rtl/cuenta1_pkg.sv | 14 +
 rtl/cuenta1_if.sv | 14 +
 rtl/cuenta1.sv | 75 +++++++
 tb/tb_cuenta1.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cuenta1_pkg.sv
// Shared types and constants for the cuenta1 counter: FSM state encoding and
// the fixed widths of the count target and count value.
package cuenta1_pkg;

   localparam int VALOR_W  = 3;
   localparam int CUENTA_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/cuenta1_if.sv
// Control/status bundle for cuenta1: the requester drives Valor/start and
// observes cuenta/fin; the counter is the slave side.
interface cuenta1_if;
   import cuenta1_pkg::*;

   logic [VALOR_W-1:0]  Valor;
   logic                start;
   logic [CUENTA_W-1:0] cuenta;
   logic                fin;

   modport master (output Valor, output start, input cuenta, input fin);
   modport slave  (input Valor, input start, output cuenta, output fin);

endinterface

// File: rtl/cuenta1.sv
// Start-triggered up-counter: counts 0..Valor, then raises fin.
// Optional macro CUENTA1_STICKY_FIN_EN keeps fin high in DONE until start/reset.
module cuenta1
   import cuenta1_pkg::*;
#(
   parameter int VALOR_W  = cuenta1_pkg::VALOR_W,
   parameter int CUENTA_W = cuenta1_pkg::CUENTA_W
) (
   input  logic      clk,
   input  logic      reset,
   cuenta1_if.slave  bus
);

   state_e              state_q,  state_d;
   logic [VALOR_W-1:0]  target_q, target_d;
   logic [CUENTA_W-1:0] cuenta_q, cuenta_d;
   logic                fin_q,    fin_d;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      cuenta_d = cuenta_q;
      fin_d    = fin_q;

      // start wins in every state: it always (re)loads the target and restarts
      if (bus.start) begin
         state_d  = COUNT;
         target_d = bus.Valor;
         cuenta_d = '0;
         fin_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            COUNT: begin
               if (cuenta_q == CUENTA_W'(target_q)) begin
                  state_d = DONE;
                  fin_d   = 1'b1;
               end else begin
                  cuenta_d = cuenta_q + CUENTA_W'(1);
               end
            end
            DONE: begin
`ifdef CUENTA1_STICKY_FIN_EN
               fin_d   = 1'b1;
`else
               state_d = IDLE;
               fin_d   = 1'b0;
`endif
            end
            default: begin
               state_d = IDLE;
               fin_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         target_q <= '0;
         cuenta_q <= '0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         cuenta_q <= cuenta_d;
         fin_q    <= fin_d;
      end
   end

   assign bus.cuenta = cuenta_q;
   assign bus.fin    = fin_q;

endmodule

// File: tb/tb_cuenta1.sv
// Directed bench for cuenta1: expected cuenta/fin pairs are queued as each
// cycle is driven and popped/compared one time unit after the clock edge.
module tb_cuenta1;
   import cuenta1_pkg::*;

`ifdef CUENTA1_STICKY_FIN_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [3:0]  c;
      logic        f;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   int     n_assert = 0;
   int     n_fail   = 0;
   exp_t   sb[$];

   cuenta1_if bus ();

   cuenta1 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_empty: got 0 entries, required 1");
         return;
      end
      e = sb.pop_front();
      n_assert++;
      assert (bus.cuenta === e.c) else begin
         n_fail++;
         $error("FAIL %s.cuenta: got %0d, required %0d", e.tag, bus.cuenta, e.c);
      end
      n_assert++;
      assert (bus.fin === e.f) else begin
         n_fail++;
         $error("FAIL %s.fin: got %0b, required %0b", e.tag, bus.fin, e.f);
      end
   endtask

   // Drive one cycle of inputs, queue the expected post-edge outputs, compare.
   task automatic cyc(input logic r, input logic s, input logic [2:0] v,
                      input logic [3:0] ec, input logic ef, input string tag);
      @(negedge clk);
      reset     = r;
      bus.start = s;
      bus.Valor = v;
      sb.push_back('{tag: tag, c: ec, f: ef});
      @(posedge clk);
      #1;
      check();
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.Valor = 3'd0;

      // Reset state
      cyc(1, 0, 3'd0, 4'd0, 1'b0, "rst0");
      cyc(1, 1, 3'd7, 4'd0, 1'b0, "rst_over_start");

      // Count to 5 with Valor wiggling during the count
      cyc(0, 1, 3'd5, 4'd0, 1'b0, "v5_start");
      for (int k = 1; k <= 5; k++)
         cyc(0, 0, 3'(k + 1), 4'(k), 1'b0, "v5_count");
      cyc(0, 0, 3'd1, 4'd5, 1'b1, "v5_fin");
      cyc(0, 0, 3'd6, 4'd5, STICKY, "v5_after");
      cyc(0, 0, 3'd2, 4'd5, STICKY, "v5_hold");

      // Valor = 0
      cyc(0, 1, 3'd0, 4'd0, 1'b0, "v0_start");
      cyc(0, 0, 3'd3, 4'd0, 1'b1, "v0_fin");
      cyc(0, 0, 3'd3, 4'd0, STICKY, "v0_after");

      // Valor = 7: reaches 7, never 8
      cyc(0, 1, 3'd7, 4'd0, 1'b0, "v7_start");
      for (int k = 1; k <= 7; k++)
         cyc(0, 0, 3'd0, 4'(k), 1'b0, "v7_count");
      cyc(0, 0, 3'd0, 4'd7, 1'b1, "v7_fin");
      cyc(0, 0, 3'd0, 4'd7, STICKY, "v7_nowrap");

      // Restart mid-count with a new target
      cyc(0, 1, 3'd5, 4'd0, 1'b0, "rs_start");
      cyc(0, 0, 3'd5, 4'd1, 1'b0, "rs_c1");
      cyc(0, 0, 3'd5, 4'd2, 1'b0, "rs_c2");
      cyc(0, 1, 3'd2, 4'd0, 1'b0, "rs_restart");
      cyc(0, 0, 3'd7, 4'd1, 1'b0, "rs_r1");
      cyc(0, 0, 3'd7, 4'd2, 1'b0, "rs_r2");
      cyc(0, 0, 3'd7, 4'd2, 1'b1, "rs_fin");
      cyc(0, 0, 3'd7, 4'd2, STICKY, "rs_after");

      // Reset mid-count, block then stays idle
      cyc(0, 1, 3'd6, 4'd0, 1'b0, "mr_start");
      for (int k = 1; k <= 3; k++)
         cyc(0, 0, 3'd6, 4'(k), 1'b0, "mr_count");
      cyc(1, 1, 3'd6, 4'd0, 1'b0, "mr_reset");
      for (int k = 0; k < 4; k++)
         cyc(0, 0, 3'd6, 4'd0, 1'b0, "mr_idle");

      // Valor = 4, then long wait: fin sticky or pulse depending on build
      cyc(0, 1, 3'd4, 4'd0, 1'b0, "sf_start");
      for (int k = 1; k <= 4; k++)
         cyc(0, 0, 3'd1, 4'(k), 1'b0, "sf_count");
      cyc(0, 0, 3'd1, 4'd4, 1'b1, "sf_fin");
      for (int k = 0; k < 10; k++)
         cyc(0, 0, 3'd1, 4'd4, STICKY, "sf_wait");
      cyc(0, 1, 3'd1, 4'd0, 1'b0, "sf_restart");
      cyc(0, 0, 3'd3, 4'd1, 1'b0, "sf_r1");
      cyc(0, 0, 3'd3, 4'd1, 1'b1, "sf_rfin");
      cyc(0, 0, 3'd3, 4'd1, STICKY, "sf_rafter");
      cyc(1, 0, 3'd3, 4'd0, 1'b0, "sf_reset");

      n_assert++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
